// File: rtl/idecode_sb_if.sv
// Decode-stage bundle: upstream instruction/decode results, register-file
// read ports, writeback-clear strobe, flush, and the registered EX-side payload.
interface idecode_sb_if #(
  parameter int WORD   = 32,
  parameter int ADDR   = 32,
  parameter int W_RD   = 3,
  parameter int W_DOPC = 8,
  parameter int W_OPC  = 6
);
  localparam int NREG = 2**W_RD;

  logic              v_i;
  logic              stall_o;
  logic [WORD-1:0]   inst_i;
  logic [ADDR-1:0]   origaddr_i;
  logic [W_DOPC-1:0] dec_dopc_i;
  logic              dec_wb_i;
  logic [WORD-1:0]   dec_imm_i;
  logic [W_RD-1:0]   r0_num_o;
  logic [W_RD-1:0]   r1_num_o;
  logic [WORD-1:0]   r0_data_i;
  logic [WORD-1:0]   r1_data_i;
  logic              wb_clr_i;
  logic [W_RD-1:0]   wb_clr_num_i;
  logic [WORD-1:0]   wb_data_i;
  logic              flush_i;
  logic              v_o;
  logic [WORD-1:0]   src_o;
  logic [WORD-1:0]   dest_o;
  logic              wb_o;
  logic [W_RD-1:0]   rd_num_o;
  logic [W_DOPC-1:0] dopc_o;
  logic [W_OPC-1:0]  opc_o;
  logic [ADDR-1:0]   origaddr_o;
  logic              stall_i;
  logic [NREG-1:0]   busy_o;

  modport slave (
    input  v_i, inst_i, origaddr_i, dec_dopc_i, dec_wb_i, dec_imm_i,
           r0_data_i, r1_data_i, wb_clr_i, wb_clr_num_i, wb_data_i,
           flush_i, stall_i,
    output stall_o, r0_num_o, r1_num_o, v_o, src_o, dest_o, wb_o,
           rd_num_o, dopc_o, opc_o, origaddr_o, busy_o
  );

  modport master (
    output v_i, inst_i, origaddr_i, dec_dopc_i, dec_wb_i, dec_imm_i,
           r0_data_i, r1_data_i, wb_clr_i, wb_clr_num_i, wb_data_i,
           flush_i, stall_i,
    input  stall_o, r0_num_o, r1_num_o, v_o, src_o, dest_o, wb_o,
           rd_num_o, dopc_o, opc_o, origaddr_o, busy_o
  );
endinterface

// File: rtl/idecode_sb.sv
// Instruction decode stage with a per-register scoreboard: operand read with
// writeback bypass, RAW/WAW hazard stall, flush, and a registered EX payload.
module idecode_sb #(
  parameter int WORD   = 32,
  parameter int ADDR   = 32,
  parameter int W_RD   = 3,
  parameter int W_DOPC = 8,
  parameter int W_OPC  = 6
) (
  input  logic         clk,
  input  logic         rst,
  idecode_sb_if.slave  bus
);
  localparam int NREG     = 2**W_RD;
  localparam int OPC_LSB  = WORD - W_OPC;
  localparam int IMMF_BIT = OPC_LSB - 1;
  localparam int RD_LSB   = IMMF_BIT - W_RD;
  localparam int RS_LSB   = RD_LSB - W_RD;

  function automatic logic [WORD-1:0] bypass(
    input logic [WORD-1:0] rf_data,
    input logic [W_RD-1:0] num,
    input logic            clr,
    input logic [W_RD-1:0] clr_num,
    input logic [WORD-1:0] wb_data
  );
    return (clr && (clr_num == num)) ? wb_data : rf_data;
  endfunction

  logic [W_RD-1:0]  rd, rs;
  logic             immf;
  logic [W_OPC-1:0] opc;
  logic             unused_inst;

  assign opc         = bus.inst_i[OPC_LSB +: W_OPC];
  assign immf        = bus.inst_i[IMMF_BIT];
  assign rd          = bus.inst_i[RD_LSB +: W_RD];
  assign rs          = bus.inst_i[RS_LSB +: W_RD];
  assign unused_inst = ^bus.inst_i[RS_LSB-1:0];

  logic              vld_p1;
  logic [WORD-1:0]   src_p1, dest_p1;
  logic              wb_p1;
  logic [W_RD-1:0]   rd_p1;
  logic [W_DOPC-1:0] dopc_p1;
  logic [W_OPC-1:0]  opc_p1;
  logic [ADDR-1:0]   addr_p1;
  logic [NREG-1:0]   sb;

  logic [NREG-1:0]   clr_vec, busy_eff, sb_nxt;
  logic [WORD-1:0]   rd_val, rs_val;
  logic              hazard, free, issue, vld_nxt;

  assign rd_val = bypass(bus.r0_data_i, rd, bus.wb_clr_i, bus.wb_clr_num_i, bus.wb_data_i);
  assign rs_val = bypass(bus.r1_data_i, rs, bus.wb_clr_i, bus.wb_clr_num_i, bus.wb_data_i);

  // A writeback completing this cycle frees its register for the same-cycle issue.
  always_comb begin
    clr_vec = '0;
    if (bus.wb_clr_i) clr_vec[bus.wb_clr_num_i] = 1'b1;
    busy_eff = sb & ~clr_vec;
    hazard   = bus.v_i & (busy_eff[rd] | (~immf & busy_eff[rs]));
    free     = ~vld_p1 | ~bus.stall_i;
    issue    = bus.v_i & ~hazard & free & ~bus.flush_i;

    sb_nxt = busy_eff;
    if (bus.flush_i && vld_p1 && wb_p1) sb_nxt[rd_p1] = 1'b0;
    if (issue && bus.dec_wb_i)          sb_nxt[rd]    = 1'b1;

    vld_nxt = vld_p1;
    if (bus.flush_i)  vld_nxt = 1'b0;
    else if (free)    vld_nxt = issue;
  end

  // ---- stage p1: control (reset) ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1 <= 1'b0;
      sb     <= '0;
    end else begin
      vld_p1 <= vld_nxt;
      sb     <= sb_nxt;
    end
  end

  // ---- stage p1: payload (no reset) ----
  always_ff @(posedge clk) begin
    if (issue) begin
      src_p1  <= immf ? bus.dec_imm_i : rs_val;
      dest_p1 <= rd_val;
      wb_p1   <= bus.dec_wb_i;
      rd_p1   <= rd;
      dopc_p1 <= bus.dec_dopc_i;
      opc_p1  <= opc;
      addr_p1 <= bus.origaddr_i;
    end
  end

  assign bus.r0_num_o   = rd;
  assign bus.r1_num_o   = rs;
  assign bus.stall_o    = hazard | (vld_p1 & bus.stall_i);
  assign bus.v_o        = vld_p1;
  assign bus.src_o      = src_p1;
  assign bus.dest_o     = dest_p1;
  assign bus.wb_o       = wb_p1;
  assign bus.rd_num_o   = rd_p1;
  assign bus.dopc_o     = dopc_p1;
  assign bus.opc_o      = opc_p1;
  assign bus.origaddr_o = addr_p1;
  assign bus.busy_o     = sb;
endmodule

// File: tb/tb_idecode_sb.sv
// Bench for idecode_sb: directed vector table, async-reset sequence, and
// randomized traffic checked against a register-level scoreboard model.
module tb_idecode_sb;
  logic clk = 1'b0;
  logic rst_n;

  idecode_sb_if #(.WORD(32), .ADDR(32), .W_RD(3), .W_DOPC(8), .W_OPC(6)) bus ();
  idecode_sb #(.WORD(32), .ADDR(32), .W_RD(3), .W_DOPC(8), .W_OPC(6)) u_dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    bit          v;
    bit          immf;
    int          rd;
    int          rs;
    bit          wb;
    logic [31:0] imm;
    logic [31:0] r0d;
    logic [31:0] r1d;
    bit          clr;
    int          clrn;
    logic [31:0] wbd;
    bit          fl;
    bit          stl;
    bit          e_stall;
    bit          e_v;
    logic [7:0]  e_busy;
    bit          chk_pl;
    logic [31:0] e_src;
    logic [31:0] e_dest;
  } vec_t;

  vec_t tbl[$];

  // Model state: one busy flag per register plus the EX-side payload.
  bit          m_busy[8];
  bit          m_v;
  logic [31:0] m_src, m_dest;
  bit          m_wb;
  int          m_rd;
  logic [7:0]  m_dopc;
  int          m_opc;
  logic [31:0] m_addr;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input int opc, input bit immf, input int rd, input int rs);
    logic [31:0] w;
    w = $urandom;
    w[31:26] = opc[5:0];
    w[25]    = immf;
    w[24:22] = rd[2:0];
    w[21:19] = rs[2:0];
    return w;
  endfunction

  function automatic vec_t row(input bit v, input int rd, input int rs, input bit immf, input bit wb,
                               input logic [31:0] imm, input logic [31:0] r0d, input logic [31:0] r1d,
                               input bit clr, input int clrn, input logic [31:0] wbd,
                               input bit fl, input bit stl,
                               input bit e_stall, input bit e_v, input logic [7:0] e_busy,
                               input bit chk_pl, input logic [31:0] e_src, input logic [31:0] e_dest);
    vec_t r;
    r.v = v; r.rd = rd; r.rs = rs; r.immf = immf; r.wb = wb; r.imm = imm;
    r.r0d = r0d; r.r1d = r1d; r.clr = clr; r.clrn = clrn; r.wbd = wbd;
    r.fl = fl; r.stl = stl; r.e_stall = e_stall; r.e_v = e_v; r.e_busy = e_busy;
    r.chk_pl = chk_pl; r.e_src = e_src; r.e_dest = e_dest;
    return r;
  endfunction

  task automatic set_in(input bit v, input int opc, input bit immf, input int rd, input int rs,
                        input bit wb, input logic [31:0] imm, input logic [31:0] r0d,
                        input logic [31:0] r1d, input bit clr, input int clrn,
                        input logic [31:0] wbd, input bit fl, input bit stl);
    bus.v_i          = v;
    bus.inst_i       = mk(opc, immf, rd, rs);
    bus.origaddr_i   = $urandom;
    bus.dec_dopc_i   = 8'($urandom);
    bus.dec_wb_i     = wb;
    bus.dec_imm_i    = imm;
    bus.r0_data_i    = r0d;
    bus.r1_data_i    = r1d;
    bus.wb_clr_i     = clr;
    bus.wb_clr_num_i = 3'(clrn);
    bus.wb_data_i    = wbd;
    bus.flush_i      = fl;
    bus.stall_i      = stl;
  endtask

  function automatic logic [7:0] model_busy();
    logic [7:0] b;
    for (int n = 0; n < 8; n++) b[n] = m_busy[n];
    return b;
  endfunction

  initial begin
    rst_n = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset v_o", bus.v_o, 0);
    chk("reset busy_o", bus.busy_o, 0);
    @(negedge clk);
    rst_n = 1'b1;

    //        v rd rs im wb imm       r0d   r1d   clr n wbd  fl st | stl v busy  pl src     dest
    tbl.push_back(row(1, 1, 2, 0, 1, 0,        'h11, 'h22, 0, 0, 0,    0, 0,  0, 1, 'h02, 1, 'h22,   'h11));
    tbl.push_back(row(1, 1, 2, 0, 1, 0,        'h33, 'h44, 0, 0, 0,    0, 0,  1, 0, 'h02, 0, 0,      0));
    tbl.push_back(row(1, 1, 2, 0, 1, 0,        'h33, 'h44, 1, 1, 'h55, 0, 0,  0, 1, 'h02, 1, 'h44,   'h55));
    tbl.push_back(row(1, 4, 1, 1, 1, 'hABCD,   'h66, 'h77, 0, 0, 0,    0, 0,  0, 1, 'h12, 1, 'hABCD, 'h66));
    for (int i = 0; i < 3; i++)
      tbl.push_back(row(1, 5, 6, 0, 0, 0,      'h88, 'h99, 0, 0, 0,    0, 1,  1, 1, 'h12, 1, 'hABCD, 'h66));
    tbl.push_back(row(1, 5, 6, 0, 0, 0,        'h88, 'h99, 0, 0, 0,    0, 0,  0, 1, 'h12, 1, 'h99,   'h88));
    tbl.push_back(row(1, 3, 5, 0, 1, 0,        'hAA, 'hBB, 0, 0, 0,    0, 0,  0, 1, 'h1A, 1, 'hBB,   'hAA));
    tbl.push_back(row(1, 6, 7, 0, 1, 0,        'hCC, 'hDD, 0, 0, 0,    1, 1,  1, 0, 'h12, 0, 0,      0));
    tbl.push_back(row(0, 0, 0, 0, 0, 0,        0,    0,    1, 1, 0,    0, 0,  0, 0, 'h10, 0, 0,      0));
    tbl.push_back(row(0, 0, 0, 0, 0, 0,        0,    0,    1, 4, 0,    0, 0,  0, 0, 'h00, 0, 0,      0));
    tbl.push_back(row(0, 0, 0, 0, 0, 0,        0,    0,    1, 2, 0,    0, 0,  0, 0, 'h00, 0, 0,      0));
    tbl.push_back(row(1, 0, 0, 0, 0, 0,        'h01, 'h02, 0, 0, 0,    0, 0,  0, 1, 'h00, 1, 'h02,   'h01));
    tbl.push_back(row(1, 2, 3, 0, 1, 0,        'h03, 'h04, 0, 0, 0,    0, 0,  0, 1, 'h04, 1, 'h04,   'h03));
    tbl.push_back(row(1, 5, 2, 0, 0, 0,        'h05, 'h06, 0, 0, 0,    0, 0,  1, 0, 'h04, 0, 0,      0));
    tbl.push_back(row(1, 5, 2, 0, 0, 0,        'h05, 'h06, 1, 2, 'h77, 0, 0,  0, 1, 'h00, 1, 'h77,   'h05));

    foreach (tbl[i]) begin
      vec_t r;
      r = tbl[i];
      @(negedge clk);
      set_in(r.v, 0, r.immf, r.rd, r.rs, r.wb, r.imm, r.r0d, r.r1d, r.clr, r.clrn, r.wbd, r.fl, r.stl);
      #2;
      chk($sformatf("row%0d stall_o", i), bus.stall_o, r.e_stall);
      chk($sformatf("row%0d r0_num_o", i), bus.r0_num_o, r.rd);
      chk($sformatf("row%0d r1_num_o", i), bus.r1_num_o, r.rs);
      @(posedge clk);
      #1;
      chk($sformatf("row%0d v_o", i), bus.v_o, r.e_v);
      chk($sformatf("row%0d busy_o", i), bus.busy_o, r.e_busy);
      if (r.chk_pl) begin
        chk($sformatf("row%0d src_o", i), bus.src_o, r.e_src);
        chk($sformatf("row%0d dest_o", i), bus.dest_o, r.e_dest);
      end
    end

    // Fill every scoreboard bit, stall, then pull reset between edges.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      set_in(1, 1, 1, i, 0, 1, 'h1, 'h2, 'h3, 0, 0, 0, 0, 0);
    end
    @(posedge clk);
    #1;
    chk("fill busy_o", bus.busy_o, 'hFF);
    @(negedge clk);
    set_in(1, 1, 0, 0, 1, 1, 0, 'h9, 'hA, 0, 0, 0, 0, 1);
    #2;
    chk("fill stall_o", bus.stall_o, 1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async rst v_o", bus.v_o, 0);
    chk("async rst busy_o", bus.busy_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    set_in(1, 2, 0, 0, 1, 1, 0, 'h123, 'h456, 0, 0, 0, 0, 0);
    #2;
    chk("post-rst stall_o", bus.stall_o, 0);
    @(posedge clk);
    #1;
    chk("post-rst v_o", bus.v_o, 1);
    chk("post-rst busy_o", bus.busy_o, 'h01);
    chk("post-rst dest_o", bus.dest_o, 'h123);
    @(negedge clk);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    chk("idle v_o", bus.v_o, 0);
    chk("idle busy_o", bus.busy_o, 0);

    m_v = 0;
    for (int n = 0; n < 8; n++) m_busy[n] = 0;

    for (int k = 0; k < 3000; k++) begin
      bit v, immf, wb, clr, fl, stl, blocked, stuck, accept, e_stall;
      int rd, rs, clrn, opc;
      logic [31:0] imm, r0d, r1d, wbd, rdv, rsv;
      bit pend[8];
      v    = ($urandom_range(0, 9) < 7);
      immf = $urandom_range(0, 1);
      wb   = ($urandom_range(0, 3) != 0);
      clr  = ($urandom_range(0, 9) < 4);
      fl   = ($urandom_range(0, 19) == 0);
      stl  = ($urandom_range(0, 9) < 3);
      rd   = $urandom_range(0, 7);
      rs   = $urandom_range(0, 7);
      clrn = $urandom_range(0, 7);
      opc  = $urandom_range(0, 63);
      imm  = $urandom;
      r0d  = $urandom;
      r1d  = $urandom;
      wbd  = $urandom;
      @(negedge clk);
      set_in(v, opc, immf, rd, rs, wb, imm, r0d, r1d, clr, clrn, wbd, fl, stl);
      #2;
      for (int n = 0; n < 8; n++) pend[n] = m_busy[n] && !(clr && clrn == n);
      blocked = v && (pend[rd] || (!immf && pend[rs]));
      stuck   = m_v && stl;
      e_stall = blocked || stuck;
      accept  = v && !blocked && !stuck && !fl;
      rdv     = (clr && clrn == rd) ? wbd : r0d;
      rsv     = (clr && clrn == rs) ? wbd : r1d;
      chk("rand stall_o", bus.stall_o, e_stall);
      chk("rand r0_num_o", bus.r0_num_o, rd);
      chk("rand r1_num_o", bus.r1_num_o, rs);

      if (clr) m_busy[clrn] = 0;
      if (fl && m_v && m_wb) m_busy[m_rd] = 0;
      if (accept && wb) m_busy[rd] = 1;
      if (fl) m_v = 0;
      else if (accept) begin
        m_v    = 1;
        m_src  = immf ? imm : rsv;
        m_dest = rdv;
        m_wb   = wb;
        m_rd   = rd;
        m_dopc = bus.dec_dopc_i;
        m_opc  = opc;
        m_addr = bus.origaddr_i;
      end else if (!stuck) m_v = 0;

      @(posedge clk);
      #1;
      chk("rand v_o", bus.v_o, m_v);
      chk("rand busy_o", bus.busy_o, model_busy());
      if (m_v) begin
        chk("rand src_o", bus.src_o, m_src);
        chk("rand dest_o", bus.dest_o, m_dest);
        chk("rand wb_o", bus.wb_o, m_wb);
        chk("rand rd_num_o", bus.rd_num_o, m_rd);
        chk("rand dopc_o", bus.dopc_o, m_dopc);
        chk("rand opc_o", bus.opc_o, m_opc);
        chk("rand origaddr_o", bus.origaddr_o, m_addr);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
